// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store sequencer: funct3 codes, access sizes, FSM states.
package mem_access_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic load_f3_ok(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic store_f3_ok(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request, data-memory and response signals of the load/store sequencer.
// master = pipeline/memory side, slave = the sequencer itself.
interface mem_access_unit_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_is_load;
  logic            req_is_store;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [4:0]      req_rd;
  logic            stall;
  logic [XLEN-1:0] mem_address;
  logic [XLEN-1:0] mem_write_data;
  logic            mem_memwrite;
  logic            mem_memread;
  logic [1:0]      mem_byte_size;
  logic            mem_sign_ext;
  logic [XLEN-1:0] mem_read_data;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;
  logic [4:0]      resp_rd;
  logic            misalign_exc;
  logic            fault_exc;
  logic [XLEN-1:0] exc_addr;

  modport master (
    output req_valid, req_is_load, req_is_store, req_funct3, req_addr,
           req_wdata, req_rd, mem_read_data,
    input  req_ready, stall, mem_address, mem_write_data, mem_memwrite,
           mem_memread, mem_byte_size, mem_sign_ext, resp_valid, resp_data,
           resp_rd, misalign_exc, fault_exc, exc_addr
  );

  modport slave (
    input  req_valid, req_is_load, req_is_store, req_funct3, req_addr,
           req_wdata, req_rd, mem_read_data,
    output req_ready, stall, mem_address, mem_write_data, mem_memwrite,
           mem_memread, mem_byte_size, mem_sign_ext, resp_valid, resp_data,
           resp_rd, misalign_exc, fault_exc, exc_addr
  );
endinterface

// File: rtl/mem_access_decode.sv
// Combinational funct3/address decode: access size, sign extension and the
// fault/misalign classification of a request.
module mem_access_decode
  import mem_access_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int XLEN      = 32
) (
  input  logic            is_load,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  output logic [1:0]      byte_size,
  output logic            sign_ext,
  output logic            misalign,
  output logic            fault
);

  logic out_of_range;
  logic bad_f3;

  always_comb begin
    byte_size    = funct3[1:0];
    sign_ext     = is_load & ~funct3[2];
    out_of_range = (addr >> ADDR_BITS) != '0;
    bad_f3       = (is_load & ~load_f3_ok(funct3)) |
                   (is_store & ~store_f3_ok(funct3));
    fault        = (is_load & is_store) | bad_f3 | out_of_range;
    // funct3[1:0]==11 is always a fault, so only half/word need alignment
    misalign     = ((byte_size == SZ_HALF) & addr[0]) |
                   ((byte_size == SZ_WORD) & (addr[1:0] != 2'b00));
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and a 2-cycle registered data
// memory: single-cycle stores, 4-cycle loads with pipeline stall.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int XLEN      = 32
) (
  input logic              clock,
  input logic              reset,
  mem_access_unit_if.slave bus
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      size_q, size_d;
  logic            sign_q, sign_d;
  logic [4:0]      rd_q, rd_d;
  logic            memread_q, memread_d;
  logic            memwrite_q, memwrite_d;
  logic            mis_q, mis_d;
  logic            flt_q, flt_d;
  logic [XLEN-1:0] exc_addr_q, exc_addr_d;

  logic [1:0] dec_size;
  logic       dec_sign, dec_mis, dec_flt;
  logic       idle, accept, ok;

  mem_access_decode #(
    .ADDR_BITS (ADDR_BITS),
    .XLEN      (XLEN)
  ) u_decode (
    .is_load   (bus.req_is_load),
    .is_store  (bus.req_is_store),
    .funct3    (bus.req_funct3),
    .addr      (bus.req_addr),
    .byte_size (dec_size),
    .sign_ext  (dec_sign),
    .misalign  (dec_mis),
    .fault     (dec_flt)
  );

  assign idle   = (state_q == ST_IDLE);
  assign accept = bus.req_valid & idle & (bus.req_is_load | bus.req_is_store);
  assign ok     = accept & ~dec_flt & ~dec_mis;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    sign_d     = sign_q;
    rd_d       = rd_q;
    exc_addr_d = exc_addr_q;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    mis_d      = 1'b0;
    flt_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ok) begin
          addr_d = bus.req_addr;
          size_d = dec_size;
          sign_d = dec_sign;
          if (bus.req_is_load) begin
            memread_d = 1'b1;
            rd_d      = bus.req_rd;
            state_d   = ST_ISSUE;
          end else begin
            memwrite_d = 1'b1;
            wdata_d    = bus.req_wdata;
          end
        end
        if (accept & (dec_flt | dec_mis)) begin
          flt_d      = dec_flt;
          mis_d      = ~dec_flt;
          exc_addr_d = bus.req_addr;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= SZ_BYTE;
      sign_q     <= 1'b0;
      rd_q       <= '0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      mis_q      <= 1'b0;
      flt_q      <= 1'b0;
      exc_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      sign_q     <= sign_d;
      rd_q       <= rd_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      mis_q      <= mis_d;
      flt_q      <= flt_d;
      exc_addr_q <= exc_addr_d;
    end
  end

  // Pulses are masked by reset so nothing reaches memory in a reset cycle.
  assign bus.req_ready      = idle & ~reset;
  assign bus.stall          = ~reset & ((state_q == ST_ISSUE) | (state_q == ST_WAIT) |
                              (idle & bus.req_valid & bus.req_is_load & ~dec_flt & ~dec_mis));
  assign bus.mem_address    = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.mem_byte_size  = size_q;
  assign bus.mem_sign_ext   = sign_q;
  assign bus.mem_memread    = memread_q & ~reset;
  assign bus.mem_memwrite   = memwrite_q & ~reset;
  assign bus.resp_valid     = (state_q == ST_RESP) & ~reset;
  assign bus.resp_data      = bus.resp_valid ? bus.mem_read_data : '0;
  assign bus.resp_rd        = bus.resp_valid ? rd_q : '0;
  assign bus.misalign_exc   = mis_q & ~reset;
  assign bus.fault_exc      = flt_q & ~reset;
  assign bus.exc_addr       = exc_addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a transaction-level reference model
// and a 2-cycle registered data-memory model.
module tb_mem_access_unit;
  localparam int XLEN = 32;
  localparam int AB   = 10;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_access_unit_if #(.XLEN(XLEN)) bus();
  mem_access_unit #(.ADDR_BITS(AB), .XLEN(XLEN)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ext_load(input logic [31:0] raw, input logic [1:0] sz, input logic sgn);
    case (sz)
      2'b00:   return sgn ? {{24{raw[7]}}, raw[7:0]} : {24'b0, raw[7:0]};
      2'b01:   return sgn ? {{16{raw[15]}}, raw[15:0]} : {16'b0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // [1] = fault, [0] = misalign (fault wins)
  function automatic logic [1:0] classify(input logic ld, input logic st,
                                          input logic [2:0] f3, input logic [31:0] a);
    logic f, m;
    f = (ld && st) || (ld && (f3 == 3 || f3 == 6 || f3 == 7)) || (st && f3 > 2) || (a >= 32'd1024);
    m = !f && ((f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0));
    return {f, m};
  endfunction

  // ---- data memory device model ----
  logic [7:0]  dmem [0:1023];
  logic [31:0] rd_stage;
  logic [9:0]  da;
  always @(posedge clock) begin
    da = bus.mem_address[9:0];
    if (bus.mem_memwrite === 1'b1)
      for (int b = 0; b < nbytes(bus.mem_byte_size); b++)
        dmem[da + 10'(b)] <= bus.mem_write_data[8*b +: 8];
    if (bus.mem_memread === 1'b1)
      rd_stage <= ext_load({dmem[da + 10'd3], dmem[da + 10'd2], dmem[da + 10'd1], dmem[da]},
                           bus.mem_byte_size, bus.mem_sign_ext);
    bus.mem_read_data <= rd_stage;
  end

  // ---- reference model ----
  logic [7:0]  ref_b [0:1023];
  int          ld_age = -1;
  bit          started = 0;
  logic        exp_wr = 0, exp_rp = 0, exp_mis = 0, exp_flt = 0, exp_sgn = 0;
  logic [31:0] exp_addr = 0, exp_wdata = 0, exp_exc = 0, exp_res = 0;
  logic [1:0]  exp_sz = 0;
  logic [4:0]  exp_tag = 0;
  logic [1:0]  cl_m;
  logic [9:0]  ma;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dmem[i]  = 8'(i * 37 + 5);
      ref_b[i] = 8'(i * 37 + 5);
    end
  end

  initial forever begin
    @(posedge clock);
    started = 1;
    exp_wr = 0; exp_rp = 0; exp_mis = 0; exp_flt = 0;
    if (reset) begin
      ld_age  = -1;
      exp_exc = 0;
    end else if (ld_age >= 0) begin
      ld_age = (ld_age == 2) ? -1 : ld_age + 1;
    end else if (bus.req_valid && (bus.req_is_load || bus.req_is_store)) begin
      cl_m = classify(bus.req_is_load, bus.req_is_store, bus.req_funct3, bus.req_addr);
      ma   = bus.req_addr[9:0];
      if (cl_m[1]) begin
        exp_flt = 1; exp_exc = bus.req_addr;
      end else if (cl_m[0]) begin
        exp_mis = 1; exp_exc = bus.req_addr;
      end else if (bus.req_is_store) begin
        exp_wr = 1; exp_addr = bus.req_addr; exp_wdata = bus.req_wdata;
        exp_sz = bus.req_funct3[1:0];
        for (int b = 0; b < nbytes(exp_sz); b++) ref_b[ma + 10'(b)] = bus.req_wdata[8*b +: 8];
      end else begin
        ld_age = 0; exp_rp = 1; exp_addr = bus.req_addr;
        exp_sz = bus.req_funct3[1:0]; exp_sgn = ~bus.req_funct3[2]; exp_tag = bus.req_rd;
        exp_res = ext_load({ref_b[ma + 10'd3], ref_b[ma + 10'd2], ref_b[ma + 10'd1], ref_b[ma]},
                           exp_sz, exp_sgn);
      end
    end
  end

  // ---- compare process + event counters ----
  int   wr_run = 0, max_run = 0, resp_seen = 0, stall_seen = 0;
  int   mis_seen = 0, flt_seen = 0, pulse_seen = 0, ready_low = 0;
  logic [1:0] cl_c;
  logic exp_stall, idle_m;

  initial forever begin
    @(negedge clock);
    if (started) begin
      idle_m = (ld_age < 0);
      cl_c = classify(bus.req_is_load, bus.req_is_store, bus.req_funct3, bus.req_addr);
      exp_stall = !reset && (ld_age == 0 || ld_age == 1 ||
                  (idle_m && bus.req_valid && bus.req_is_load && cl_c == 2'b00));
      chk("req_ready",    32'(bus.req_ready),    32'(!reset && idle_m));
      chk("stall",        32'(bus.stall),        32'(exp_stall));
      chk("mem_memwrite", 32'(bus.mem_memwrite), 32'(exp_wr && !reset));
      chk("mem_memread",  32'(bus.mem_memread),  32'(exp_rp && !reset));
      chk("resp_valid",   32'(bus.resp_valid),   32'(!reset && ld_age == 2));
      chk("misalign_exc", 32'(bus.misalign_exc), 32'(exp_mis && !reset));
      chk("fault_exc",    32'(bus.fault_exc),    32'(exp_flt && !reset));
      chk("exc_addr",     bus.exc_addr,          exp_exc);
      if (exp_wr && !reset) begin
        chk("wr_addr",  bus.mem_address,           exp_addr);
        chk("wr_data",  bus.mem_write_data,        exp_wdata);
        chk("wr_size",  32'(bus.mem_byte_size),    32'(exp_sz));
      end
      if (exp_rp && !reset) begin
        chk("rd_addr",  bus.mem_address,           exp_addr);
        chk("rd_size",  32'(bus.mem_byte_size),    32'(exp_sz));
        chk("rd_sign",  32'(bus.mem_sign_ext),     32'(exp_sgn));
      end
      if (!reset && ld_age == 2) begin
        chk("resp_data", bus.resp_data,        exp_res);
        chk("resp_rd",   32'(bus.resp_rd),     32'(exp_tag));
      end
    end
    if (bus.mem_memwrite === 1'b1) begin
      wr_run++;
      if (wr_run > max_run) max_run = wr_run;
    end else wr_run = 0;
    if (bus.resp_valid === 1'b1) resp_seen++;
    if (bus.stall === 1'b1) stall_seen++;
    if (bus.misalign_exc === 1'b1) mis_seen++;
    if (bus.fault_exc === 1'b1) flt_seen++;
    if (bus.mem_memwrite === 1'b1 || bus.mem_memread === 1'b1) pulse_seen++;
    if (reset === 1'b0 && bus.req_ready !== 1'b1) ready_low++;
  end

  // ---- driver ----
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                       input bit hold);
    bit acc;
    acc = 0;
    bus.req_valid = 1; bus.req_is_load = ld; bus.req_is_store = st;
    bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = wd; bus.req_rd = rd;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clock);
      if (bus.req_ready === 1'b1) acc = 1;
      @(posedge clock); #1;
    end
    if (!acc) begin
      total++; bad++;
      $display("FAIL accept_timeout: got no accept want accept @%0t", $time);
    end
    if (!hold) bus.req_valid = 0;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                         output logic [31:0] data, output int lat, output int stalls);
    int s0;
    bit got;
    s0 = stall_seen; got = 0; lat = 0; data = 'x;
    issue(1, 0, f3, a, 0, rd, 0);
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clock); lat++;
      if (bus.resp_valid === 1'b1) begin got = 1; data = bus.resp_data; end
    end
    #1;
    stalls = stall_seen - s0;
    if (!got) begin
      total++; bad++;
      $display("FAIL resp_timeout: got no resp_valid want resp_valid @%0t", $time);
    end
  endtask

  task automatic idle_cycles(input int n);
    bus.req_valid = 0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  logic [31:0] d;
  int lat, stl, snap_a, snap_b, snap_c;
  logic [2:0] lf3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    reset = 1;
    bus.req_valid = 0; bus.req_is_load = 0; bus.req_is_store = 0;
    bus.req_funct3 = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.req_rd = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(posedge clock); #1;
    reset = 0;

    // store then load word
    issue(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 0);
    do_load(3'd2, 32'h10, 5'd5, d, lat, stl);
    chk("lw_data", d, 32'hDEADBEEF);
    chk("lw_latency", 32'(lat), 32'd3);
    chk("lw_stall_cycles", 32'(stl), 32'd3);

    // byte sign/zero extension
    issue(0, 1, 3'd0, 32'h21, 32'h12345680, 0, 0);
    do_load(3'd0, 32'h21, 5'd3, d, lat, stl);
    chk("lb_data", d, 32'hFFFFFF80);
    do_load(3'd4, 32'h21, 5'd0, d, lat, stl);
    chk("lbu_data", d, 32'h00000080);

    // misalign and range fault
    snap_a = mis_seen; snap_b = pulse_seen;
    issue(1, 0, 3'd1, 32'h13, 0, 5'd1, 0);
    idle_cycles(2);
    chk("lh_misalign_count", 32'(mis_seen - snap_a), 32'd1);
    chk("lh_exc_addr", bus.exc_addr, 32'h13);
    snap_a = flt_seen;
    issue(1, 0, 3'd2, 32'h400, 0, 5'd1, 0);
    idle_cycles(2);
    chk("lw_range_fault", 32'(flt_seen - snap_a), 32'd1);
    chk("exc_no_mem_pulse", 32'(pulse_seen - snap_b), 32'd0);
    chk("range_exc_addr", bus.exc_addr, 32'h400);

    // back-to-back stores
    max_run = 0; snap_a = ready_low;
    issue(0, 1, 3'd2, 32'h0, 32'h11111111, 0, 1);
    issue(0, 1, 3'd2, 32'h4, 32'h22222222, 0, 1);
    issue(0, 1, 3'd2, 32'h8, 32'h33333333, 0, 0);
    idle_cycles(3);
    chk("b2b_write_run", 32'(max_run), 32'd3);
    chk("b2b_ready_drops", 32'(ready_low - snap_a), 32'd0);

    // reset while waiting on a load
    snap_a = resp_seen;
    issue(1, 0, 3'd2, 32'h4, 0, 5'd7, 0);
    @(posedge clock); #1;
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    @(negedge clock);
    chk("post_reset_ready", 32'(bus.req_ready), 32'd1);
    idle_cycles(4);
    chk("reset_no_resp", 32'(resp_seen - snap_a), 32'd0);

    // illegal funct3 and load+store
    snap_a = flt_seen;
    issue(1, 0, 3'd3, 32'h20, 0, 5'd2, 0);
    issue(1, 1, 3'd2, 32'h24, 0, 5'd2, 0);
    idle_cycles(2);
    chk("illegal_faults", 32'(flt_seen - snap_a), 32'd2);
    chk("illegal_exc_addr", bus.exc_addr, 32'h24);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [2:0] f3;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r == 9) begin
        idle_cycles($urandom_range(1, 3));
        continue;
      end
      if (r < 4) f3 = lf3s[$urandom_range(0, 4)];
      else       f3 = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 19) == 0) f3 = 3'($urandom);
      a = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 9) < 7) begin
        if (f3[1:0] == 2'd1) a[0] = 1'b0;
        if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 19) == 0) a = 32'h400 + 32'($urandom_range(0, 4095));
      issue(r < 4 || r == 8, r >= 4, f3, a, $urandom, 5'($urandom), 1'($urandom_range(0, 1)));
    end
    idle_cycles(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer sitting between the MEM-stage pipeline register and the 2-cycle registered data memory.
- Decodes funct3 into byte_size/sign_ext and checks alignment and range.
- Drives the memory ports as registered one-cycle pulses, tracks the 2-cycle read latency and stalls the pipeline until load data is valid.
- Returns load data with its destination tag to writeback; stores complete without a response.

Parameters:
ADDR_BITS, 10, implemented data-memory address width; any address at or above 2**ADDR_BITS faults.
XLEN, 32, data/address width.

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  MEM-stage request present
req_ready  out  1  unit can accept; high only in IDLE
req_is_load  in  1  request is a load
req_is_store  in  1  request is a store
req_funct3  in  3  RV32I load/store funct3
req_addr  in  XLEN  effective address from ALU
req_wdata  in  XLEN  store data (rs2)
req_rd  in  5  load destination register
stall  out  1  hold IF..MEM pipeline registers
mem_address  out  XLEN  to data memory, registered
mem_write_data  out  XLEN  to data memory, registered
mem_memwrite  out  1  one-cycle write pulse
mem_memread  out  1  one-cycle read pulse
mem_byte_size  out  2  00 byte, 01 half, 10 word
mem_sign_ext  out  1  1 for LB/LH
mem_read_data  in  XLEN  extended read data from data memory
resp_valid  out  1  load result valid this cycle
resp_data  out  XLEN  load result (= mem_read_data while resp_valid)
resp_rd  out  5  destination tag of resp_data
misalign_exc  out  1  one-cycle pulse, misaligned access
fault_exc  out  1  one-cycle pulse, illegal funct3, load+store both set, or out-of-range address
exc_addr  out  XLEN  faulting address, held until next exception

Behaviour:
- Reset values: req_ready=0 during reset and 1 after; every other output is 0; state=IDLE.
- States: IDLE, ISSUE, WAIT, RESP.
- Accept: on an edge with req_valid & req_ready & (req_is_load | req_is_store). Request fields are latched on that edge.
- Checks are applied at accept, in this priority order:
  - fault: load and store both set; load funct3 in {011,110,111}; store funct3 not in {000,001,010}; addr >= 2**ADDR_BITS.
  - misalign: half with addr[0]=1; word with addr[1:0]!=0.
  - On fault or misalign: no memory pulse; the exception pulses in the cycle after the accept edge; exc_addr=req_addr; state stays IDLE.
- Valid store: mem_memwrite=1 plus address, data and size for exactly one cycle after accept. State stays IDLE, so back-to-back stores sustain 1 per cycle.
- Valid load timeline (E0 = accept edge, state becomes ISSUE):
  - ISSUE: mem_memread=1 for one cycle, mem_sign_ext = ~funct3[2]. Data memory samples at E1.
  - E1 -> WAIT; E2 -> RESP.
  - RESP: resp_valid=1, resp_data=mem_read_data, resp_rd=latched rd for exactly one cycle.
  - E3 -> IDLE.
  - Load-to-result latency is 3 cycles; load throughput is 1 per 4 cycles.
- stall = (state==ISSUE) | (state==WAIT) | (state==IDLE & req_valid & req_is_load & load passes checks). stall is low in RESP so the pipeline advances with the result.
- A request presented while not IDLE is not accepted; req_valid must be held.
- mem_memread and mem_memwrite are never high in the same cycle, and never high while reset is high.
- Reset mid-load: next edge returns to IDLE, clears pulses, and no resp_valid is produced.
- rd=x0 is still returned; writeback ignores it.

Decomposition:
- Shared package mem_access_pkg:
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - byte_size encodings (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10).
  - State encoding.
- One combinational sub-module, mem_access_decode: funct3 + addr + load/store flags -> byte_size, sign_ext, misalign, fault.

Test Plan:
- LW addr=0x10 after SW 0xDEADBEEF to 0x10 -> store pulse 1 cycle after accept; load resp_valid 3 cycles after accept, resp_data=0xDEADBEEF, stall high exactly 3 cycles.
- SB 0x80 to 0x21 then LB/LBU from 0x21 -> resp_data 0xFFFFFF80 and 0x00000080 respectively.
- LH addr=0x13 -> misalign_exc pulse, exc_addr=0x13, no memread; LW addr=0x400 (ADDR_BITS=10) -> fault_exc, no memory pulse.
- Three back-to-back SW to 0x0,0x4,0x8 -> three consecutive memwrite cycles, req_ready never drops.
- reset asserted in WAIT -> memread low, no resp_valid, req_ready=1 the cycle after reset deasserts.
- funct3=011 load, and a request with both load and store set -> fault_exc each, state remains IDLE.
